// File: rtl/serv_sleep_pkg.sv
// -----------------------------------------------------------------------------
// serv_sleep_pkg
//
// Purpose:
//   Shared definitions for the SERV sleep/wakeup controller: the controller
//   state encoding and a helper that sizes counters so that they are never
//   zero bits wide.
//
// Contents:
//   sleep_state_e  - RUN / DRAIN / SLEEP / WAKE controller states
//   clog2Min1()    - ceil(log2(value)) clamped to a minimum of 1
// -----------------------------------------------------------------------------
package serv_sleep_pkg;

    // Controller states. The numeric values are fixed so that the state
    // register can be decoded directly when probing the design.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        SLEEP = 2'd2,
        WAKE  = 2'd3
    } sleep_state_e;

    // Width helper for counters whose range can collapse to a single value.
    // $clog2(1) is 0, which would give a zero-width vector, so the result is
    // clamped to at least one bit.
    function automatic int clog2Min1(input int value);
        int bits;
        bits = $clog2(value);
        if (bits < 1) begin
            bits = 1;
        end
        return bits;
    endfunction

endpackage : serv_sleep_pkg

// File: rtl/serv_irq_pend.sv
// -----------------------------------------------------------------------------
// serv_irq_pend
//
// Purpose:
//   Per-channel interrupt pending latches for the SERV sleep controller, plus
//   the wake reduction that tells the sleep FSM an enabled interrupt is
//   waiting.
//
// Ports:
//   i_clk       - clock
//   i_rst_n     - asynchronous active-low reset, clears all pending bits
//   i_irq       - level interrupt requests, one per channel
//   i_irq_en    - per-channel enables
//   i_pend_clr  - one-cycle clear strobes, one per channel
//   o_pend      - registered pending bits
//   o_wake      - at least one pending bit is set on an enabled channel
// -----------------------------------------------------------------------------
module serv_irq_pend
    import serv_sleep_pkg::*;
#(
    parameter int NUM_IRQ = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_IRQ-1:0] i_irq,
    input  logic [NUM_IRQ-1:0] i_irq_en,
    input  logic [NUM_IRQ-1:0] i_pend_clr,
    output logic [NUM_IRQ-1:0] o_pend,
    output logic               o_wake
);

    logic [NUM_IRQ-1:0] pend_q;
    logic [NUM_IRQ-1:0] pend_d;

    // A clear strobe drops a held bit, but a new enabled request in the same
    // cycle sets it again, so an interrupt arriving while software clears an
    // older one is never lost.
    always_comb begin
        pend_d = (pend_q & ~i_pend_clr) | (i_irq & i_irq_en);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Re-masking with the live enables lets software disable a channel and
    // immediately stop its already-latched bit from waking the core.
    assign o_wake = |(pend_q & i_irq_en);
    assign o_pend = pend_q;

endmodule : serv_irq_pend

// File: rtl/serv_sleep_ctrl.sv
// -----------------------------------------------------------------------------
// serv_sleep_ctrl
//
// Purpose:
//   Sleep/wakeup controller for the SERV core. A WFI that completes with no
//   enabled interrupt pending starts a handshake with the clock/power
//   controller; once accepted, the core clock enable is dropped until an
//   enabled interrupt is pending, after which a fixed stabilisation delay runs
//   before the core clock is re-enabled and a wakeup pulse is sent to the core.
//
// Parameters:
//   NUM_IRQ     - number of interrupt channels (bit 0 timer, bit 1 external)
//   WAKE_DELAY  - clock-gated cycles spent stabilising before resuming
//                 (0 behaves like 1)
//
// Ports:
//   i_clk         - clock
//   i_rst_n       - asynchronous active-low reset
//   i_irq         - level interrupt requests
//   i_irq_en      - per-channel interrupt enables
//   i_pend_clr    - one-cycle clear strobes for pending bits
//   i_wfi         - current instruction is WFI
//   i_cnt_done    - serial bit counter done (WFI has finished executing)
//   i_sleep_ack   - clock controller accepts the sleep request
//   o_sleep_req   - request to enter sleep (DRAIN and SLEEP)
//   o_sleeping    - core clock gated, in SLEEP
//   o_clk_en      - core clock enable
//   o_wakeup_req  - one-cycle wakeup pulse to the core
//   o_pend        - latched pending bits
// -----------------------------------------------------------------------------
module serv_sleep_ctrl
    import serv_sleep_pkg::*;
#(
    parameter int NUM_IRQ    = 2,
    parameter int WAKE_DELAY = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_IRQ-1:0] i_irq,
    input  logic [NUM_IRQ-1:0] i_irq_en,
    input  logic [NUM_IRQ-1:0] i_pend_clr,
    input  logic               i_wfi,
    input  logic               i_cnt_done,
    input  logic               i_sleep_ack,
    output logic               o_sleep_req,
    output logic               o_sleeping,
    output logic               o_clk_en,
    output logic               o_wakeup_req,
    output logic [NUM_IRQ-1:0] o_pend
);

    // The counter only ever holds values 0 .. WAKE_CYCLES-1, so its width is
    // derived from the delay and is not meant to be overridden.
    localparam int CNT_W       = clog2Min1(WAKE_DELAY + 1);
    localparam int WAKE_CYCLES = (WAKE_DELAY < 1) ? 1 : WAKE_DELAY;
    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);

    sleep_state_e     state_q;
    sleep_state_e     state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             wakeup_q;
    logic             wakeup_d;
    logic             sleep_req_q;
    logic             sleeping_q;
    logic             clk_en_q;
    logic             wake;

    serv_irq_pend #(
        .NUM_IRQ (NUM_IRQ)
    ) u_irq_pend (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_irq      (i_irq),
        .i_irq_en   (i_irq_en),
        .i_pend_clr (i_pend_clr),
        .o_pend     (o_pend),
        .o_wake     (wake)
    );

    // Next-state logic. WFI completion is only looked at in RUN and the sleep
    // acknowledge only in DRAIN, so stray strobes in other states are harmless.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wakeup_d = 1'b0;

        case (state_q)
            RUN: begin
                // A WFI with an enabled interrupt already pending completes as
                // a NOP; the core still gets a wakeup pulse so it resumes the
                // same way it would after a real sleep.
                if (i_wfi && i_cnt_done) begin
                    if (wake) begin
                        wakeup_d = 1'b1;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end

            DRAIN: begin
                // Once the clock controller has accepted, sleep is committed
                // even if an interrupt showed up in the same cycle; the normal
                // SLEEP -> WAKE path then handles that interrupt.
                if (i_sleep_ack) begin
                    state_d = SLEEP;
                end else if (wake) begin
                    state_d  = RUN;
                    wakeup_d = 1'b1;
                end
            end

            SLEEP: begin
                if (wake) begin
                    state_d = WAKE;
                    cnt_d   = WAKE_LOAD;
                end
            end

            WAKE: begin
                // The delay always runs to completion; wake dropping here
                // does not send the core back to sleep.
                if (cnt_q == '0) begin
                    state_d  = RUN;
                    wakeup_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State, counter and all outputs are registered. The output registers are
    // loaded from the decode of the next state so they line up exactly with
    // the state register they describe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            wakeup_q    <= 1'b0;
            sleep_req_q <= 1'b0;
            sleeping_q  <= 1'b0;
            clk_en_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wakeup_q    <= wakeup_d;
            sleep_req_q <= (state_d == DRAIN) || (state_d == SLEEP);
            sleeping_q  <= (state_d == SLEEP);
            clk_en_q    <= (state_d == RUN) || (state_d == DRAIN);
        end
    end

    assign o_sleep_req  = sleep_req_q;
    assign o_sleeping   = sleeping_q;
    assign o_clk_en     = clk_en_q;
    assign o_wakeup_req = wakeup_q;

endmodule : serv_sleep_ctrl
